dds_reg_sequencer: RTL and testbench

- Parametrised successor to the fixed-order AD9852 configuration writer.
- Accepts an arbitrary list of {address, data} register writes through an internal FIFO.
- Replays the list on the DDS parallel port with programmable setup, strobe and hold timing, then issues one I/O-update pulse.
- Sits between the mode/frequency control logic and the DDS chip pins, so new modes need no new step tables.

---
 rtl/dds_seq_pkg.sv | 59 +++++
 rtl/dds_seq_fifo.sv | 77 +++++++
 rtl/dds_reg_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_dds_reg_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_seq_pkg
// Description : Shared types and constants for the DDS register sequencer:
//               sequencer state encoding, AD9852 register map constants,
//               the native {addr, data} write entry and a small helper
//               used to size the timing counter.
//               Optional build macro: DDS_SEQ_MASTER_RESET_EN adds the
//               MRST state to the state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_seq_pkg;

  // Sequencer states. MRST exists only when the master-reset prologue is built.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
`ifdef DDS_SEQ_MASTER_RESET_EN
    ST_MRST   = 3'd1,
`endif
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_UPDATE = 3'd5,
    ST_DONE   = 3'd6
  } dds_seq_state_t;

  // Native AD9852 parallel-port widths.
  localparam int AD_AW = 6;
  localparam int AD_DW = 8;

  // AD9852 register map (byte addresses on the parallel port).
  localparam logic [AD_AW-1:0] PTW1_FIRST = 6'h00;
  localparam logic [AD_AW-1:0] PTW1_LAST  = 6'h01;
  localparam logic [AD_AW-1:0] PTW2_FIRST = 6'h02;
  localparam logic [AD_AW-1:0] PTW2_LAST  = 6'h03;
  localparam logic [AD_AW-1:0] FTW1_FIRST = 6'h04;
  localparam logic [AD_AW-1:0] FTW1_LAST  = 6'h09;
  localparam logic [AD_AW-1:0] FTW2_FIRST = 6'h0A;
  localparam logic [AD_AW-1:0] FTW2_LAST  = 6'h0F;
  localparam logic [AD_AW-1:0] DFW_FIRST  = 6'h10;
  localparam logic [AD_AW-1:0] DFW_LAST   = 6'h15;
  localparam logic [AD_AW-1:0] RAMP_FIRST = 6'h1A;
  localparam logic [AD_AW-1:0] RAMP_LAST  = 6'h1C;
  localparam logic [AD_AW-1:0] CTRL_PLL   = 6'h1E;
  localparam logic [AD_AW-1:0] CTRL_MODE  = 6'h1F;
  localparam logic [AD_AW-1:0] CTRL_UPD   = 6'h20;

  // One register write at the chip's native widths.
  typedef struct packed {
    logic [AD_AW-1:0] addr;
    logic [AD_DW-1:0] data;
  } dds_entry_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : dds_seq_pkg
`default_nettype wire

// File: rtl/dds_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dds_seq_fifo
// Description : Single-clock show-ahead FIFO holding pending register writes.
//               rdata always presents the head entry; pop advances it.
//               Pushes while full and pops while empty are ignored.
// Ports       : clk, rst (async, active high)
//               push, wdata   - enqueue request and entry
//               pop           - dequeue request
//               rdata         - head entry (valid while !empty)
//               full, empty   - occupancy flags
//               level         - occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module dds_seq_fifo #(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 14,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the pointers define which words are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule : dds_seq_fifo
`default_nettype wire

// File: rtl/dds_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dds_reg_sequencer
// Description : Replays a queued list of {address, data} register writes on
//               the AD9852 parallel port with programmable setup / strobe /
//               hold timing, then issues one I/O-update (UDCLK) pulse.
//               Optional build macro: DDS_SEQ_MASTER_RESET_EN - each burst
//               starts with a DDS master-reset pulse of RST_CYCLES cycles
//               followed by 2 quiet cycles.
// Ports       : CLK, RST (async, active high)
//               PUSH, PUSH_ADDR, PUSH_DATA - enqueue one register write
//               START                      - begin a burst (acted on in IDLE)
//               FULL, LEVEL                - FIFO status
//               BUSY, READY                - burst in progress / done pulse
//               AOUT, DOUT, WRB, UDCLK     - DDS parallel port
//               DDS_RESET                  - DDS master reset
//               CONFIGERR                  - sticky overflow / empty-start flag
// Revision    : 1.0 - initial release
// ============================================================================
module dds_reg_sequencer
  import dds_seq_pkg::*;
#(
  parameter int AW         = 6,
  parameter int DW         = 8,
  parameter int DEPTH      = 32,
  parameter int T_SETUP    = 2,
  parameter int T_WR       = 2,
  parameter int T_HOLD     = 1,
  parameter int UPD_CYCLES = 4,
  parameter int RST_CYCLES = 10
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   PUSH,
  input  logic [AW-1:0]          PUSH_ADDR,
  input  logic [DW-1:0]          PUSH_DATA,
  input  logic                   START,
  output logic                   FULL,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   BUSY,
  output logic                   READY,
  output logic [AW-1:0]          AOUT,
  output logic [DW-1:0]          DOUT,
  output logic                   WRB,
  output logic                   UDCLK,
  output logic                   DDS_RESET,
  output logic                   CONFIGERR
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = AW + DW;

  // MRST reuses the timing counter for reset pulse plus its 2 quiet cycles.
`ifdef DDS_SEQ_MASTER_RESET_EN
  localparam int TMAX = max_of(max_of(max_of(T_SETUP, T_WR), max_of(T_HOLD, UPD_CYCLES)),
                               RST_CYCLES + 2);
`else
  localparam int TMAX = max_of(max_of(T_SETUP, T_WR), max_of(T_HOLD, UPD_CYCLES));
`endif
  localparam int CW = $clog2(TMAX) + 1;

  localparam logic [CW-1:0] CNT_SETUP = CW'(T_SETUP);
  localparam logic [CW-1:0] CNT_WR    = CW'(T_WR);
  localparam logic [CW-1:0] CNT_HOLD  = CW'(T_HOLD);
  localparam logic [CW-1:0] CNT_UPD   = CW'(UPD_CYCLES);

`ifdef DDS_SEQ_MASTER_RESET_EN
  localparam dds_seq_state_t  FIRST_ST  = ST_MRST;
  localparam logic [CW-1:0]   FIRST_CNT = CW'(RST_CYCLES + 2);
`else
  localparam dds_seq_state_t  FIRST_ST  = ST_SETUP;
  localparam logic [CW-1:0]   FIRST_CNT = CNT_SETUP;
`endif

  // Elaboration-time parameter sanity.
  if (T_SETUP < 1 || T_WR < 1 || T_HOLD < 1 || UPD_CYCLES < 1 || RST_CYCLES < 1)
  begin : g_bad_timing
    $error("dds_reg_sequencer: timing parameters must be >= 1");
  end
  if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dds_reg_sequencer: DEPTH must be a power of two in 4..256");
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t         head;
  logic           fifo_full, fifo_empty;
  logic [LW-1:0]  fifo_level;
  logic           pop;
  logic           push_ok;
  logic           last_tick;
  logic           bus_active;
  logic [CW-1:0]  cnt_dec;

  dds_seq_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cfgerr_q, cfgerr_d;

  dds_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (PUSH),
    .wdata ({PUSH_ADDR, PUSH_DATA}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign push_ok   = PUSH && !fifo_full;
  assign last_tick = (cnt_q == CW'(1));
  assign cnt_dec   = cnt_q - CW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cfgerr_d = cfgerr_q;
    pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (!fifo_empty) begin
            cfgerr_d = 1'b0;
            state_d  = FIRST_ST;
            cnt_d    = FIRST_CNT;
          end else begin
            cfgerr_d = 1'b1;
          end
        end
      end
`ifdef DDS_SEQ_MASTER_RESET_EN
      ST_MRST: begin
        if (last_tick) begin
          state_d = ST_SETUP;
          cnt_d   = CNT_SETUP;
        end else begin
          cnt_d = cnt_dec;
        end
      end
`endif
      ST_SETUP: begin
        if (last_tick) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_WR;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_STROBE: begin
        if (last_tick) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_HOLD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_HOLD: begin
        if (last_tick) begin
          pop = 1'b1;
          // An entry accepted on this same edge keeps the burst going.
          if (fifo_level > LW'(1) || push_ok) begin
            state_d = ST_SETUP;
            cnt_d   = CNT_SETUP;
          end else begin
            state_d = ST_UPDATE;
            cnt_d   = CNT_UPD;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_UPDATE: begin
        if (last_tick) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Overflow sets the flag after any clear, so it is never lost.
    if (PUSH && fifo_full) cfgerr_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cfgerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cfgerr_q <= cfgerr_d;
    end
  end

  // The head entry cannot change while presented: pops happen only on the
  // final HOLD edge and pushes never touch the head slot of a non-empty FIFO.
  assign bus_active = (state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                      (state_q == ST_HOLD);

  assign AOUT      = bus_active ? head.addr : '0;
  assign DOUT      = bus_active ? head.data : '0;
  assign WRB       = (state_q != ST_STROBE);
  assign UDCLK     = (state_q == ST_UPDATE);
  assign BUSY      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign READY     = (state_q == ST_DONE);
  assign FULL      = fifo_full;
  assign LEVEL     = fifo_level;
  assign CONFIGERR = cfgerr_q;

`ifdef DDS_SEQ_MASTER_RESET_EN
  // The last two MRST counts are the quiet gap after the reset pulse.
  assign DDS_RESET = (state_q == ST_MRST) && (cnt_q > CW'(2));
`else
  assign DDS_RESET = 1'b0;
`endif

endmodule : dds_reg_sequencer
`default_nettype wire

// File: tb/tb_dds_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_reg_sequencer
// Description : Self-checking bench for dds_reg_sequencer (DEPTH=4 instance).
//               A bus monitor records every WRB-low window, UDCLK pulse,
//               BUSY window and READY pulse; each burst is then compared with
//               hand-computed expectations from a vector table or from
//               directed corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_reg_sequencer;
  import dds_seq_pkg::*;

`ifdef DDS_SEQ_MASTER_RESET_EN
  localparam int MR_EXTRA = 12;   // 10 reset cycles + 2 quiet cycles
  localparam int MR_LEN   = 10;
`else
  localparam int MR_EXTRA = 0;
  localparam int MR_LEN   = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PUSH = 1'b0;
  logic [5:0] PUSH_ADDR = '0;
  logic [7:0] PUSH_DATA = '0;
  logic       START = 1'b0;
  logic       FULL, BUSY, READY, WRB, UDCLK, DDS_RESET, CONFIGERR;
  logic [2:0] LEVEL;
  logic [5:0] AOUT;
  logic [7:0] DOUT;

  dds_reg_sequencer #(
    .AW(6), .DW(8), .DEPTH(4), .T_SETUP(2), .T_WR(2), .T_HOLD(1),
    .UPD_CYCLES(4), .RST_CYCLES(10)
  ) dut (
    .CLK(CLK), .RST(RST), .PUSH(PUSH), .PUSH_ADDR(PUSH_ADDR),
    .PUSH_DATA(PUSH_DATA), .START(START), .FULL(FULL), .LEVEL(LEVEL),
    .BUSY(BUSY), .READY(READY), .AOUT(AOUT), .DOUT(DOUT), .WRB(WRB),
    .UDCLK(UDCLK), .DDS_RESET(DDS_RESET), .CONFIGERR(CONFIGERR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- bus monitor (samples on falling edge) ----------------
  int         cyc = 0;
  int         busy_rise_cyc = 0, busy_rises = 0, busy_len = 0;
  int         fall_ofs [$];
  logic [5:0] w_addr [$];
  logic [7:0] w_data [$];
  int         w_len [$];
  int         cur_w = 0;
  int         ud_rises = 0, ud_ofs = 0, ud_len = 0;
  int         ready_cnt = 0, rb_err = 0, stab_err = 0, ud_bus_err = 0, mr_len = 0;
  logic       wrb_prev = 1'b1, busy_prev = 1'b0, ud_prev = 1'b0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (BUSY && !busy_prev) begin
      busy_rise_cyc = cyc;
      busy_rises++;
    end
    if (!BUSY && busy_prev) busy_len = cyc - busy_rise_cyc;
    if (!WRB && wrb_prev) begin
      fall_ofs.push_back(cyc - busy_rise_cyc);
      w_addr.push_back(AOUT);
      w_data.push_back(DOUT);
      cur_w = 1;
    end else if (!WRB) begin
      cur_w++;
      if (AOUT != w_addr[$] || DOUT != w_data[$]) stab_err++;
    end
    if (WRB && !wrb_prev) w_len.push_back(cur_w);
    if (UDCLK && !ud_prev) begin
      ud_rises++;
      ud_ofs = cyc - busy_rise_cyc;
      ud_len = 1;
    end else if (UDCLK) begin
      ud_len++;
    end
    if (UDCLK && (AOUT != 6'h00 || DOUT != 8'h00)) ud_bus_err++;
    if (READY) begin
      ready_cnt++;
      if (BUSY) rb_err++;
    end
    if (DDS_RESET) mr_len++;
    wrb_prev  = WRB;
    busy_prev = BUSY;
    ud_prev   = UDCLK;
  end

  task automatic clr();
    fall_ofs.delete(); w_addr.delete(); w_data.delete(); w_len.delete();
    busy_rises = 0; busy_len = 0; ud_rises = 0; ud_ofs = 0; ud_len = 0;
    ready_cnt = 0; rb_err = 0; stab_err = 0; ud_bus_err = 0; mr_len = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic push_entry(input logic [13:0] e);
    PUSH = 1'b1; PUSH_ADDR = e[13:8]; PUSH_DATA = e[7:0];
    step();
    PUSH = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int i;
    for (i = 0; i < 400; i++) begin
      step();
      if (ready_cnt > 0) break;
    end
    if (i == 400) chk({tag, " ready timeout"}, 0, 1);
    step(); step();
  endtask

  task automatic check_burst(input string tag, input int n, input logic [13:0] ent [4],
                             input int exp_busy, input int exp_ud_ofs);
    logic [13:0] e;
    chk({tag, " writes"}, fall_ofs.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < w_addr.size()) begin
        e = ent[i];
        chk($sformatf("%s addr[%0d]", tag, i), int'(w_addr[i]), int'(e[13:8]));
        chk($sformatf("%s data[%0d]", tag, i), int'(w_data[i]), int'(e[7:0]));
        chk($sformatf("%s fall_ofs[%0d]", tag, i), fall_ofs[i], MR_EXTRA + 2 + 5 * i);
      end
      if (i < w_len.size())
        chk($sformatf("%s wrb_low[%0d]", tag, i), w_len[i], 2);
    end
    chk({tag, " busy_len"},   busy_len,   exp_busy + MR_EXTRA);
    chk({tag, " ud_pulses"},  ud_rises,   1);
    chk({tag, " ud_len"},     ud_len,     4);
    chk({tag, " ud_ofs"},     ud_ofs,     exp_ud_ofs + MR_EXTRA);
    chk({tag, " ready"},      ready_cnt,  1);
    chk({tag, " ready_busy"}, rb_err,     0);
    chk({tag, " bus_stable"}, stab_err,   0);
    chk({tag, " ud_bus0"},    ud_bus_err, 0);
    chk({tag, " dds_reset"},  mr_len,     MR_LEN);
    chk({tag, " level_end"},  int'(LEVEL), 0);
    chk({tag, " cfgerr_end"}, int'(CONFIGERR), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          n;
    logic [13:0] ent [4];
    logic        exp_full;
    int          exp_busy;
    int          exp_ud_ofs;
  } vec_t;

  vec_t vecs [4];

  task automatic run_vec(input int k);
    clr();
    for (int i = 0; i < vecs[k].n; i++) push_entry(vecs[k].ent[i]);
    chk($sformatf("v%0d level", k), int'(LEVEL), vecs[k].n);
    chk($sformatf("v%0d full", k), int'(FULL), int'(vecs[k].exp_full));
    pulse_start();
    wait_ready($sformatf("v%0d", k));
    check_burst($sformatf("v%0d", k), vecs[k].n, vecs[k].ent, vecs[k].exp_busy,
                vecs[k].exp_ud_ofs);
  endtask

  logic [13:0] hs [4];

  initial begin
    // 3 writes: 3*5 cycles of writes + 4 UDCLK cycles of BUSY
    vecs[0].n = 3; vecs[0].exp_full = 1'b0; vecs[0].exp_busy = 19; vecs[0].exp_ud_ofs = 15;
    vecs[0].ent[0] = {CTRL_UPD, 8'h60};
    vecs[0].ent[1] = {CTRL_MODE, 8'h00};
    vecs[0].ent[2] = {FTW1_LAST, 8'hAB};
    vecs[0].ent[3] = 14'h0;
    vecs[1].n = 1; vecs[1].exp_full = 1'b0; vecs[1].exp_busy = 9;  vecs[1].exp_ud_ofs = 5;
    vecs[1].ent[0] = {CTRL_PLL, 8'h5A};
    vecs[1].ent[1] = 14'h0; vecs[1].ent[2] = 14'h0; vecs[1].ent[3] = 14'h0;
    vecs[2].n = 4; vecs[2].exp_full = 1'b1; vecs[2].exp_busy = 24; vecs[2].exp_ud_ofs = 20;
    vecs[2].ent[0] = {6'h04, 8'h11};
    vecs[2].ent[1] = {6'h05, 8'h22};
    vecs[2].ent[2] = {6'h06, 8'h33};
    vecs[2].ent[3] = {6'h07, 8'h44};
    vecs[3].n = 2; vecs[3].exp_full = 1'b0; vecs[3].exp_busy = 14; vecs[3].exp_ud_ofs = 10;
    vecs[3].ent[0] = {PTW1_FIRST, 8'hFF};
    vecs[3].ent[1] = {6'h3F, 8'h01};
    vecs[3].ent[2] = 14'h0; vecs[3].ent[3] = 14'h0;

    // ---- reset state (RST still asserted) ----
    #1;
    chk("rst WRB", int'(WRB), 1);
    chk("rst BUSY", int'(BUSY), 0);
    chk("rst READY", int'(READY), 0);
    chk("rst UDCLK", int'(UDCLK), 0);
    chk("rst AOUT", int'(AOUT), 0);
    chk("rst DOUT", int'(DOUT), 0);
    chk("rst LEVEL", int'(LEVEL), 0);
    chk("rst FULL", int'(FULL), 0);
    chk("rst CONFIGERR", int'(CONFIGERR), 0);
    chk("rst DDS_RESET", int'(DDS_RESET), 0);
    repeat (3) step();
    RST = 1'b0;
    step();

    // ---- START with empty FIFO ----
    clr();
    pulse_start();
    repeat (10) step();
    chk("empty writes", fall_ofs.size(), 0);
    chk("empty busy_rises", busy_rises, 0);
    chk("empty ready", ready_cnt, 0);
    chk("empty cfgerr", int'(CONFIGERR), 1);
    chk("empty BUSY", int'(BUSY), 0);

    // ---- table: the first valid burst also clears CONFIGERR ----
    for (int k = 0; k < 4; k++) run_vec(k);

    // ---- overflow: 5 pushes into DEPTH=4 ----
    clr();
    for (int i = 0; i < 5; i++) push_entry({6'(6'h10 + i), 8'(8'h01 + i)});
    chk("ovf FULL", int'(FULL), 1);
    chk("ovf LEVEL", int'(LEVEL), 4);
    chk("ovf cfgerr", int'(CONFIGERR), 1);
    hs[0] = {6'h10, 8'h01}; hs[1] = {6'h11, 8'h02};
    hs[2] = {6'h12, 8'h03}; hs[3] = {6'h13, 8'h04};
    pulse_start();
    wait_ready("ovf");
    check_burst("ovf", 4, hs, 24, 20);

    // ---- push during the first entry's SETUP joins the same burst ----
    clr();
    hs[0] = {CTRL_MODE, 8'h00}; hs[1] = {FTW2_LAST, 8'h55};
    hs[2] = 14'h0; hs[3] = 14'h0;
    push_entry(hs[0]);
    pulse_start();
    push_entry(hs[1]);
    wait_ready("late");
    check_burst("late", 2, hs, 14, 10);

    // ---- asynchronous reset during STROBE ----
    clr();
    push_entry({6'h04, 8'h11});
    push_entry({6'h05, 8'h22});
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (!WRB) break;
    end
    chk("arst strobe seen", int'(WRB), 0);
    #2 RST = 1'b1;
    #1;
    chk("arst WRB", int'(WRB), 1);
    chk("arst BUSY", int'(BUSY), 0);
    chk("arst LEVEL", int'(LEVEL), 0);
    chk("arst UDCLK", int'(UDCLK), 0);
    step();
    RST = 1'b0;
    step();
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dds_reg_sequencer
`default_nettype wire
